attack_input_buffer: RTL and testbench
======================================

# attack_input_buffer

Front end for the player attack path. Conditions one raw attack button into the frame-synchronous attack request consumed by the attack timing stage. The block synchronizes and debounces the button, detects the press edge, and holds that press until a frame tick on which the attack stage can accept it. A press that arrives mid-frame, or during an attack, is therefore not lost. A buffered press that is never accepted expires after a bounded number of frames.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 500000: consecutive clk cycles the synchronized button must differ from the stable level before the stable level flips. Must be ≥1.
- BUFFER_FRAMES, default 6: number of SCEN ticks a press stays buffered without being consumed before it is dropped. Must be ≥1.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- SCEN  in  1  one-clk pulse per video frame; shared frame tick with the attack stage.
- btn_raw  in  1  raw attack button, active-high, asynchronous to clk, bouncing.
- attack_enable  in  1  same signal that gates the attack stage.
- attack_busy  in  1  attack stage is in an attack.
- attack1  out  1  buffered attack request to the attack stage. Registered level, high while a press is pending.
- btn_stable  out  1  debounced button level.
- drop_pulse  out  1  one-clk pulse when a pending press expires unconsumed.

## Operation
- Synchronizer: two flops, btn_raw → s1 → s2. Reset value is 0.
- Debounce counter: cnt has width $clog2(DEBOUNCE_CYCLES+1).
  - If s2 == btn_stable: cnt ← 0.
  - Else if cnt == DEBOUNCE_CYCLES−1: btn_stable ← s2 and cnt ← 0.
  - Else: cnt ← cnt+1.
  - Any glitch back to the stable level restarts the count.
- Press event: the edge on which btn_stable transitions 0→1. The release edge produces no event.
- Request FSM has two states, IDLE and PENDING. attack1 = (state == PENDING).
- age counter: width max(1, $clog2(BUFFER_FRAMES)). It counts SCEN ticks spent in PENDING.
- Consume condition: SCEN && attack_enable && !attack_busy while in PENDING. This matches the attack stage's own start condition, so on that tick the stage samples attack1 = 1 and starts.
- Transitions, in priority order per clk edge:
  - A press event → PENDING, age ← 0. This applies from any state, including the same edge as a consume or expire. A press during PENDING refreshes age, and only one request is ever queued.
  - PENDING and consume → IDLE.
  - PENDING and SCEN without consume:
    - If age == BUFFER_FRAMES−1: → IDLE and drop_pulse ← 1.
    - Else: age ← age+1.
  - Aging happens on every SCEN, including when attack_enable is 0.
- drop_pulse defaults to 0 each clk. It is never asserted on an edge where a press event occurs.
- Holding the button produces exactly one request. A new request requires a release followed by a press.

## Timing
- Reset (reset=0): s1, s2, btn_stable, cnt, state=IDLE, age, attack1, and drop_pulse are all 0, asynchronously. Deassertion is synchronous to clk.
- Press latency: btn_raw is held high from before edge 0 with btn_stable=0. s2=1 after edge 2. btn_stable and attack1 both rise on edge 2+DEBOUNCE_CYCLES.
- Consume: attack1 is 1 during the SCEN cycle and goes to 0 on that SCEN edge. The attack stage sees exactly one SCEN with attack1=1 per accepted press.
- Expire: attack1 falls and drop_pulse rises on the BUFFER_FRAMES-th non-consuming SCEN edge after entry.
- SCEN coincident with a press event: the press wins, age=0, and that SCEN is not counted.
- Reset mid-PENDING clears the request immediately with no drop_pulse.

## Test plan
Bench settings: DEBOUNCE_CYCLES=4, BUFFER_FRAMES=3.
- Clean press: btn_raw rises before edge 0 and is held. btn_stable and attack1 rise at edge 6. The first SCEN with attack_enable=1 and attack_busy=0 occurs at edge 10; attack1=0 after edge 10. Still holding the button, later SCENs leave attack1 at 0.
- Bounce: btn_raw toggles 1,0,1,0 every 2 clk and then holds 1. btn_stable rises exactly 6 edges after the final rise. Only one request results.
- Buffer during attack: attack_busy=1 through SCENs 1–2 after the press, then 0 at SCEN 3. attack1 stays high through SCEN 2, is consumed at SCEN 3, and drop_pulse stays 0.
- Expiry: after the press, attack_busy=1 for 3 SCENs. drop_pulse is high for exactly 1 clk on the 3rd SCEN edge, and attack1 falls on the same edge.
- Refresh and coincidence: a second press at age=2 resets age to 0, and the request survives 3 more SCENs. A press event on the same edge as a consuming SCEN leaves attack1=1 with age=0.
- Reset: assert reset=0 mid-PENDING and mid-debounce count. All outputs go to 0 immediately, without waiting for a clk edge. After release, a held button needs 6 more edges to re-register.

Source files
------------

// File: rtl/attack_input_buffer.sv
// -----------------------------------------------------------------------------
// attack_input_buffer
//
// Conditions the raw attack button into a frame-synchronous attack request.
// The button is synchronized (two flops), debounced, and its 0->1 stable edge
// is held as a pending request until a frame tick (SCEN) on which the attack
// stage can start. A pending request that is never accepted expires after
// BUFFER_FRAMES frame ticks and reports that with a one-cycle drop_pulse.
//
// State table (request FSM):
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no press waiting; attack1 low
//   PENDING | one press buffered; attack1 high, age counts SCEN ticks waited
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-low reset
//   SCEN           in   one-cycle frame tick shared with the attack stage
//   btn_raw        in   raw, bouncing, asynchronous attack button
//   attack_enable  in   gate of the attack stage
//   attack_busy    in   attack stage currently in an attack
//   attack1        out  registered request level, high while a press is pending
//   btn_stable     out  debounced button level
//   drop_pulse     out  one-cycle pulse when a pending press expires
// -----------------------------------------------------------------------------
module attack_input_buffer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BUFFER_FRAMES   = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic SCEN,
  input  logic btn_raw,
  input  logic attack_enable,
  input  logic attack_busy,
  output logic attack1,
  output logic btn_stable,
  output logic drop_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // $clog2(1) is 0, so a single-frame buffer still gets a 1-bit counter
  localparam int AGE_W = (BUFFER_FRAMES > 2) ? $clog2(BUFFER_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(BUFFER_FRAMES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic [AGE_W-1:0] age;
  state_t           state;

  logic stable_flip;
  logic press_event;
  logic consume;

  // The stable level flips on the edge where the count completes; a press is
  // that flip going to 1, so the FSM sees it on the same edge btn_stable rises.
  assign stable_flip = (s2 != btn_stable) && (cnt == CNT_LAST);
  assign press_event = stable_flip && s2;
  assign consume     = SCEN && attack_enable && !attack_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      btn_stable <= 1'b0;
      cnt        <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      if (s2 == btn_stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_stable <= s2;
        cnt        <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      age        <= '0;
      attack1    <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      if (press_event) begin
        // A new press wins over consume/expire on the same edge and restarts
        // the wait; only one request is ever held.
        state   <= PENDING;
        attack1 <= 1'b1;
        age     <= '0;
      end else if ((state == PENDING) && SCEN) begin
        if (consume) begin
          state   <= IDLE;
          attack1 <= 1'b0;
          age     <= '0;
        end else if (age == AGE_LAST) begin
          state      <= IDLE;
          attack1    <= 1'b0;
          drop_pulse <= 1'b1;
          age        <= '0;
        end else begin
          age <= age + AGE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_attack_input_buffer.sv
module tb_attack_input_buffer;

  localparam int DEB = 4;
  localparam int BUF = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic SCEN = 1'b0;
  logic btn_raw = 1'b0;
  logic attack_enable = 1'b0;
  logic attack_busy = 1'b0;
  logic attack1;
  logic btn_stable;
  logic drop_pulse;

  int checks = 0;
  int failures = 0;

  attack_input_buffer #(
    .DEBOUNCE_CYCLES(DEB),
    .BUFFER_FRAMES(BUF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .SCEN(SCEN),
    .btn_raw(btn_raw),
    .attack_enable(attack_enable),
    .attack_busy(attack_busy),
    .attack1(attack1),
    .btn_stable(btn_stable),
    .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  // Behavioural reference: button history as a delay line, debounce as the
  // length of the current run of samples that disagree with the stable level,
  // and the request as a flag plus the number of frames it has waited.
  bit m_pipe[2];
  int m_run;
  bit m_stable;
  bit m_pend;
  int m_waited;
  bit m_drop;

  function automatic void model_clear();
    m_pipe[0] = 0; m_pipe[1] = 0;
    m_run = 0; m_stable = 0; m_pend = 0; m_waited = 0; m_drop = 0;
  endfunction

  function automatic void model_edge();
    bit seen;
    bit pressed;
    seen = m_pipe[1];
    pressed = 0;
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = btn_raw;
    if (seen != m_stable) begin
      m_run++;
      if (m_run == DEB) begin
        m_stable = seen;
        m_run = 0;
        pressed = seen;
      end
    end else begin
      m_run = 0;
    end
    m_drop = 0;
    if (pressed) begin
      m_pend = 1;
      m_waited = 0;
    end else if (m_pend && SCEN) begin
      if (attack_enable && !attack_busy) begin
        m_pend = 0;
      end else begin
        m_waited++;
        if (m_waited == BUF) begin
          m_pend = 0;
          m_drop = 1;
        end
      end
    end
  endfunction

  // Advance one clock edge; outputs are sampled 1ns after the edge.
  task automatic tick();
    if (reset) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic press_button();
    btn_raw = 1'b1;
    repeat (DEB + 2) tick();
  endtask

  task automatic release_button();
    btn_raw = 1'b0;
    repeat (DEB + 2) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (attack1 !== 1'b0) begin failures++; $display("FAIL reset_attack1: got %0b expected 0", attack1); end
    checks++;
    if (btn_stable !== 1'b0) begin failures++; $display("FAIL reset_btn_stable: got %0b expected 0", btn_stable); end
    checks++;
    if (drop_pulse !== 1'b0) begin failures++; $display("FAIL reset_drop_pulse: got %0b expected 0", drop_pulse); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_clean_press();
    attack_enable = 1'b1;
    attack_busy = 1'b0;
    btn_raw = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (btn_stable !== (e == 6)) begin failures++; $display("FAIL clean_stable_edge%0d: got %0b expected %0b", e, btn_stable, e == 6); end
      checks++;
      if (attack1 !== (e == 6)) begin failures++; $display("FAIL clean_attack1_edge%0d: got %0b expected %0b", e, attack1, e == 6); end
    end
    repeat (3) tick();
    SCEN = 1'b1;
    checks++;
    if (attack1 !== 1'b1) begin failures++; $display("FAIL clean_attack1_in_scen: got %0b expected 1", attack1); end
    tick();
    SCEN = 1'b0;
    checks++;
    if (attack1 !== 1'b0) begin failures++; $display("FAIL clean_consumed: got %0b expected 0", attack1); end
    checks++;
    if (drop_pulse !== 1'b0) begin failures++; $display("FAIL clean_no_drop: got %0b expected 0", drop_pulse); end
    for (int f = 0; f < 4; f++) begin
      SCEN = 1'b1;
      tick();
      SCEN = 1'b0;
      tick();
      checks++;
      if (attack1 !== 1'b0) begin failures++; $display("FAIL clean_hold_no_repeat%0d: got %0b expected 0", f, attack1); end
    end
    release_button();
    checks++;
    if (btn_stable !== 1'b0) begin failures++; $display("FAIL clean_release: got %0b expected 0", btn_stable); end
  endtask

  task automatic test_bounce();
    int rises;
    bit prev;
    rises = 0;
    prev = attack1;
    attack_enable = 1'b1;
    attack_busy = 1'b0;
    for (int p = 0; p < 4; p++) begin
      btn_raw = (p % 2 == 0);
      repeat (2) begin
        tick();
        checks++;
        if (btn_stable !== 1'b0) begin failures++; $display("FAIL bounce_glitch_stable: got %0b expected 0", btn_stable); end
        if (attack1 && !prev) rises++;
        prev = attack1;
      end
    end
    btn_raw = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (btn_stable !== (e == 6)) begin failures++; $display("FAIL bounce_stable_edge%0d: got %0b expected %0b", e, btn_stable, e == 6); end
      if (attack1 && !prev) rises++;
      prev = attack1;
    end
    repeat (10) begin
      tick();
      if (attack1 && !prev) rises++;
      prev = attack1;
    end
    SCEN = 1'b1;
    tick();
    SCEN = 1'b0;
    repeat (4) begin
      tick();
      if (attack1 && !prev) rises++;
      prev = attack1;
    end
    checks++;
    if (rises !== 1) begin failures++; $display("FAIL bounce_one_request: got %0d expected 1", rises); end
    checks++;
    if (attack1 !== 1'b0) begin failures++; $display("FAIL bounce_consumed: got %0b expected 0", attack1); end
    release_button();
  endtask

  task automatic test_buffer_during_attack();
    attack_enable = 1'b1;
    attack_busy = 1'b0;
    press_button();
    attack_busy = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      if (f == 3) attack_busy = 1'b0;
      SCEN = 1'b1;
      tick();
      SCEN = 1'b0;
      checks++;
      if (attack1 !== (f < 3)) begin failures++; $display("FAIL busy_attack1_scen%0d: got %0b expected %0b", f, attack1, f < 3); end
      checks++;
      if (drop_pulse !== 1'b0) begin failures++; $display("FAIL busy_no_drop_scen%0d: got %0b expected 0", f, drop_pulse); end
      repeat (2) tick();
    end
    release_button();
  endtask

  task automatic test_expiry();
    attack_enable = 1'b1;
    attack_busy = 1'b0;
    press_button();
    attack_busy = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      SCEN = 1'b1;
      tick();
      SCEN = 1'b0;
      checks++;
      if (drop_pulse !== (f == 3)) begin failures++; $display("FAIL expiry_drop_scen%0d: got %0b expected %0b", f, drop_pulse, f == 3); end
      checks++;
      if (attack1 !== (f < 3)) begin failures++; $display("FAIL expiry_attack1_scen%0d: got %0b expected %0b", f, attack1, f < 3); end
      tick();
      checks++;
      if (drop_pulse !== 1'b0) begin failures++; $display("FAIL expiry_drop_width%0d: got %0b expected 0", f, drop_pulse); end
      tick();
    end
    attack_busy = 1'b0;
    release_button();
  endtask

  task automatic test_refresh();
    attack_enable = 1'b1;
    attack_busy = 1'b1;
    press_button();
    repeat (2) begin
      SCEN = 1'b1; tick(); SCEN = 1'b0; tick();
    end
    release_button();
    press_button();
    checks++;
    if (attack1 !== 1'b1) begin failures++; $display("FAIL refresh_still_pending: got %0b expected 1", attack1); end
    for (int f = 1; f <= 3; f++) begin
      SCEN = 1'b1; tick(); SCEN = 1'b0;
      checks++;
      if (attack1 !== (f < 3)) begin failures++; $display("FAIL refresh_attack1_scen%0d: got %0b expected %0b", f, attack1, f < 3); end
      checks++;
      if (drop_pulse !== (f == 3)) begin failures++; $display("FAIL refresh_drop_scen%0d: got %0b expected %0b", f, drop_pulse, f == 3); end
      tick();
    end
    release_button();

    // Press landing on a consuming frame tick: the press wins and age restarts.
    press_button();
    SCEN = 1'b1; tick(); SCEN = 1'b0; tick();
    btn_raw = 1'b0;
    repeat (DEB + 2) tick();
    btn_raw = 1'b1;
    repeat (DEB + 1) tick();
    attack_busy = 1'b0;
    SCEN = 1'b1;
    tick();
    SCEN = 1'b0;
    checks++;
    if (attack1 !== 1'b1) begin failures++; $display("FAIL coincide_attack1: got %0b expected 1", attack1); end
    attack_busy = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      SCEN = 1'b1; tick(); SCEN = 1'b0;
      checks++;
      if (attack1 !== (f < 3)) begin failures++; $display("FAIL coincide_age_scen%0d: got %0b expected %0b", f, attack1, f < 3); end
      tick();
    end
    attack_busy = 1'b0;
    release_button();
  endtask

  task automatic test_reset_mid();
    attack_enable = 1'b1;
    attack_busy = 1'b0;
    press_button();
    btn_raw = 1'b0;
    repeat (4) tick();
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (attack1 !== 1'b0) begin failures++; $display("FAIL midreset_attack1: got %0b expected 0", attack1); end
    checks++;
    if (btn_stable !== 1'b0) begin failures++; $display("FAIL midreset_stable: got %0b expected 0", btn_stable); end
    checks++;
    if (drop_pulse !== 1'b0) begin failures++; $display("FAIL midreset_drop: got %0b expected 0", drop_pulse); end
    btn_raw = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (btn_stable !== (e == 6)) begin failures++; $display("FAIL midreset_reregister_edge%0d: got %0b expected %0b", e, btn_stable, e == 6); end
      checks++;
      if (drop_pulse !== 1'b0) begin failures++; $display("FAIL midreset_no_drop_edge%0d: got %0b expected 0", e, drop_pulse); end
    end
    SCEN = 1'b1; tick(); SCEN = 1'b0;
    release_button();
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    reset = 1'b0;
    model_clear();
    btn_raw = 1'b0; SCEN = 1'b0; attack_enable = 1'b0; attack_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        btn_raw = $urandom_range(0, 1);
        hold = $urandom_range(1, 10);
      end
      hold--;
      SCEN = ($urandom_range(0, 3) == 0);
      attack_enable = ($urandom_range(0, 4) != 0);
      attack_busy = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (attack1 !== m_pend) begin failures++; $display("FAIL random_attack1 cycle %0d: got %0b expected %0b", c, attack1, m_pend); end
      checks++;
      if (btn_stable !== m_stable) begin failures++; $display("FAIL random_stable cycle %0d: got %0b expected %0b", c, btn_stable, m_stable); end
      checks++;
      if (drop_pulse !== m_drop) begin failures++; $display("FAIL random_drop cycle %0d: got %0b expected %0b", c, drop_pulse, m_drop); end
    end
    SCEN = 1'b0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_clean_press();
    test_bounce();
    test_buffer_during_attack();
    test_expiry();
    test_refresh();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
